// File: rtl/bck_token_skid_pipe.sv
// Stall-decoupled input slice for the backward datapath: a free-running register
// chain feeds a skid FIFO, drained by a stall-gated output register.
module bck_token_skid_pipe #(
    parameter int DATA_W         = 1024,
    parameter int STATUS_W       = 6,
    parameter int READ_NUM_WIDTH = 6,
    parameter int STAGES         = 1,
    parameter int SKID_DEPTH     = 8,
    parameter int STALL_LAT      = 2,
    parameter int DROP_BUBBLES   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STATUS_W-1:0]         in_status,
    input  logic [READ_NUM_WIDTH-1:0]   in_read_num,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        stall,
    output logic                        stall_up,
    output logic [STATUS_W-1:0]         out_status,
    output logic [READ_NUM_WIDTH-1:0]   out_read_num,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(SKID_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        drained
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(SKID_DEPTH);
    localparam logic [LVL_W-1:0] SU_THRESH = LVL_W'(SKID_DEPTH - (STAGES + STALL_LAT));
    localparam logic             KEEP_BUBBLES = (DROP_BUBBLES == 0);

    typedef struct packed {
        logic [STATUS_W-1:0]       status;
        logic [READ_NUM_WIDTH-1:0] read_num;
        logic [DATA_W-1:0]         data;
    } tok_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    // Up/down occupancy update; simultaneous push and pop leave it unchanged.
    function automatic logic [LVL_W-1:0] lvl_next(input logic [LVL_W-1:0] l,
                                                  input logic up, input logic dn);
        logic [LVL_W-1:0] r;
        r = l;
        if (up && !dn) begin
            r = l + LVL_W'(1);
        end else if (dn && !up) begin
            r = l - LVL_W'(1);
        end
        return r;
    endfunction

    tok_t             stg_q [STAGES];
    tok_t             stg_d [STAGES];
    tok_t             mem_q [SKID_DEPTH];
    tok_t             tail_tok;
    tok_t             out_q, out_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             stall_up_q, stall_up_d;
    logic             tail_vld, push_req, push, pop, full, drop;
    logic             chain_empty;

    // ---- input chain: free-running, ignores stall ----
    always_comb begin
        stg_d[0] = '{status: in_status, read_num: in_read_num, data: in_data};
        for (int i = 1; i < STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    // ---- skid FIFO: push from the last chain stage, pop into the output register ----
    always_comb begin
        tail_tok   = stg_q[STAGES-1];
        tail_vld   = (tail_tok.status != '0);
        push_req   = tail_vld || KEEP_BUBBLES;
        full       = (level_q == FULL_LVL);
        pop        = !stall && (level_q != '0);
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d    = lvl_next(level_q, push, pop);
        overflow_d = overflow_q || drop;
        stall_up_d = (level_q >= SU_THRESH);
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= tail_tok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            stall_up_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            stall_up_q <= stall_up_d;
        end
    end

    // ---- output stage: holds under stall, status drops to BUBBLE when starved ----
    always_comb begin
        out_d = out_q;
        if (!stall) begin
            if (level_q != '0) begin
                out_d = mem_q[rd_ptr_q];
            end else begin
                out_d.status = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    always_comb begin
        chain_empty = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (stg_q[i].status != '0) begin
                chain_empty = 1'b0;
            end
        end
    end

    assign drained      = chain_empty && (level_q == '0);
    assign stall_up     = stall_up_q;
    assign overflow     = overflow_q;
    assign fifo_level   = level_q;
    assign out_status   = out_q.status;
    assign out_read_num = out_q.read_num;
    assign out_data     = out_q.data;

endmodule

// File: tb/tb_bck_token_skid_pipe.sv
// Bench for bck_token_skid_pipe: per-cycle vector table, scoreboarded output
// monitor, and hand-timed sequences for stall, overflow, full-flow and reset.
module tb_bck_token_skid_pipe;

    localparam int DW = 64;
    localparam int SW = 6;
    localparam int RW = 6;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] in_status;
    logic [RW-1:0] in_read_num;
    logic [DW-1:0] in_data;
    logic          stall;

    logic          stall_up, overflow, drained;
    logic [SW-1:0] out_status;
    logic [RW-1:0] out_read_num;
    logic [DW-1:0] out_data;
    logic [LW-1:0] fifo_level;

    logic          k_stall_up, k_overflow, k_drained;
    logic [SW-1:0] k_out_status;
    logic [RW-1:0] k_out_read_num;
    logic [DW-1:0] k_out_data;
    logic [LW-1:0] k_fifo_level;

    always #5 clk = ~clk;

    bck_token_skid_pipe #(
        .DATA_W(DW), .STATUS_W(SW), .READ_NUM_WIDTH(RW), .STAGES(1),
        .SKID_DEPTH(8), .STALL_LAT(2), .DROP_BUBBLES(1)
    ) dut (
        .clk(clk), .rst(rst), .in_status(in_status), .in_read_num(in_read_num),
        .in_data(in_data), .stall(stall), .stall_up(stall_up), .out_status(out_status),
        .out_read_num(out_read_num), .out_data(out_data), .fifo_level(fifo_level),
        .overflow(overflow), .drained(drained)
    );

    bck_token_skid_pipe #(
        .DATA_W(DW), .STATUS_W(SW), .READ_NUM_WIDTH(RW), .STAGES(1),
        .SKID_DEPTH(8), .STALL_LAT(2), .DROP_BUBBLES(0)
    ) dut_keep (
        .clk(clk), .rst(rst), .in_status(in_status), .in_read_num(in_read_num),
        .in_data(in_data), .stall(stall), .stall_up(k_stall_up), .out_status(k_out_status),
        .out_read_num(k_out_read_num), .out_data(k_out_data), .fifo_level(k_fifo_level),
        .overflow(k_overflow), .drained(k_drained)
    );

    typedef struct packed {
        logic [SW-1:0] st;
        logic [RW-1:0] rn;
        logic [DW-1:0] d;
    } tok_t;

    typedef struct {
        logic          s;
        tok_t          t;
        logic [SW-1:0] e_st;
        logic [RW-1:0] e_rn;
        logic [LW-1:0] e_lvl;
        logic          e_su;
        logic          e_dr;
    } vec_t;

    tok_t sb[$];
    tok_t exp_cur;
    vec_t tv[11];
    int   checks = 0;
    int   errors = 0;
    logic mon_stall, mon_rst;
    int   sent;
    logic su_prev, su_now, saw_su;
    logic [LW-1:0] lvl_before;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic tok_t mk(input int n);
        tok_t t;
        t.st = SW'((n % 63) + 1);
        t.rn = RW'(n);
        t.d  = {32'(n) * 32'h9E37_79B1, 32'hC0DE_0000 | 32'(n)};
        return t;
    endfunction

    function automatic tok_t mkt(input logic [SW-1:0] st, input logic [RW-1:0] rn, input int n);
        tok_t t;
        t    = mk(n);
        t.st = st;
        t.rn = rn;
        return t;
    endfunction

    task automatic drv(input logic s, input tok_t t, input bit track);
        stall       = s;
        in_status   = t.st;
        in_read_num = t.rn;
        in_data     = t.d;
        if (track && t.st != '0) sb.push_back(t);
    endtask

    task automatic step(input logic s, input tok_t t, input bit track);
        drv(s, t, track);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drv(1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1'b0, '0, 1'b0);
        chk({nm, "_sb_empty"}, 64'(sb.size()), 0);
        step(1'b0, '0, 1'b0);
        chk({nm, "_level0"}, fifo_level, 0);
    endtask

    // Output monitor: after an unstalled edge a non-BUBBLE output must be the next
    // scoreboard entry; under stall the previous output must be held unchanged.
    always @(posedge clk) begin
        mon_stall = stall;
        mon_rst   = rst;
        #1;
        if (!mon_rst) begin
            exp_cur = '0;
        end else begin
            if (!mon_stall) begin
                if (out_status != '0) begin
                    if (sb.size() == 0) chk("sb_unexpected_token", out_status, 0);
                    else exp_cur = sb.pop_front();
                end else begin
                    exp_cur.st = '0;
                end
            end
            chk("mon_status", out_status, exp_cur.st);
            chk("mon_read_num", out_read_num, exp_cur.rn);
            chk("mon_data", out_data, exp_cur.d);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{s:1'b0, t:mkt(6'b001000, 6'd5, 1), e_st:6'd0, e_rn:6'd0, e_lvl:4'd0, e_su:1'b0, e_dr:1'b0};
        tv[1]  = '{s:1'b0, t:'0,                     e_st:6'd0, e_rn:6'd0, e_lvl:4'd1, e_su:1'b0, e_dr:1'b0};
        tv[2]  = '{s:1'b0, t:'0,                     e_st:6'd8, e_rn:6'd5, e_lvl:4'd0, e_su:1'b0, e_dr:1'b1};
        tv[3]  = '{s:1'b0, t:'0,                     e_st:6'd0, e_rn:6'd5, e_lvl:4'd0, e_su:1'b0, e_dr:1'b1};
        tv[4]  = '{s:1'b0, t:mkt(6'd3, 6'd7, 2),     e_st:6'd0, e_rn:6'd5, e_lvl:4'd0, e_su:1'b0, e_dr:1'b0};
        tv[5]  = '{s:1'b1, t:mkt(6'd4, 6'd9, 3),     e_st:6'd0, e_rn:6'd5, e_lvl:4'd1, e_su:1'b0, e_dr:1'b0};
        tv[6]  = '{s:1'b1, t:'0,                     e_st:6'd0, e_rn:6'd5, e_lvl:4'd2, e_su:1'b0, e_dr:1'b0};
        tv[7]  = '{s:1'b0, t:'0,                     e_st:6'd3, e_rn:6'd7, e_lvl:4'd1, e_su:1'b0, e_dr:1'b0};
        tv[8]  = '{s:1'b1, t:'0,                     e_st:6'd3, e_rn:6'd7, e_lvl:4'd1, e_su:1'b0, e_dr:1'b0};
        tv[9]  = '{s:1'b0, t:'0,                     e_st:6'd4, e_rn:6'd9, e_lvl:4'd0, e_su:1'b0, e_dr:1'b1};
        tv[10] = '{s:1'b0, t:'0,                     e_st:6'd0, e_rn:6'd9, e_lvl:4'd0, e_su:1'b0, e_dr:1'b1};

        do_reset();
        chk("rst_out_status", out_status, 0);
        chk("rst_out_read_num", out_read_num, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_stall_up", stall_up, 0);
        chk("rst_drained", drained, 1);

        // Latency (presented cycle t, visible t+3), starvation and stall hold.
        for (int i = 0; i < 11; i++) begin
            step(tv[i].s, tv[i].t, 1'b1);
            chk($sformatf("tv%0d_out_status", i), out_status, tv[i].e_st);
            chk($sformatf("tv%0d_out_read_num", i), out_read_num, tv[i].e_rn);
            chk($sformatf("tv%0d_level", i), fifo_level, tv[i].e_lvl);
            chk($sformatf("tv%0d_stall_up", i), stall_up, tv[i].e_su);
            chk($sformatf("tv%0d_drained", i), drained, tv[i].e_dr);
        end

        // Streaming with a stall window and an upstream that reacts one cycle late.
        do_reset();
        sent = 0; su_prev = 1'b0; saw_su = 1'b0;
        for (int c = 0; c < 400 && (sent < 20 || sb.size() != 0); c++) begin
            su_now     = stall_up;
            lvl_before = fifo_level;
            if (sent < 20 && !su_prev) begin
                drv(c >= 5 && c <= 14, mk(101 + sent), 1'b1);
                sent++;
            end else begin
                drv(c >= 5 && c <= 14, '0, 1'b0);
            end
            su_prev = su_now;
            @(negedge clk);
            chk("t2_stall_up", stall_up, lvl_before >= 4'd5);
            if (stall_up) saw_su = 1'b1;
        end
        chk("t2_all_delivered", 64'(sent == 20 && sb.size() == 0), 1);
        chk("t2_overflow", overflow, 0);
        chk("t2_stall_up_seen", saw_su, 1);
        drain("t2");

        // Full FIFO with simultaneous push/pop: level pinned at 8, nothing lost.
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) step(i <= 8, mk(301 + i), 1'b1);
            else step(1'b0, '0, 1'b0);
            if (i >= 8) begin
                chk("t4_level", fifo_level, 8);
                chk("t4_overflow", overflow, 0);
            end
        end
        drain("t4");

        // Stall held, stall_up ignored: tokens 9..12 lost, overflow sticky.
        do_reset();
        for (int i = 0; i <= 13; i++) begin
            if (i < 12) step(1'b1, mk(201 + i), i < 8);
            else step(1'b1, '0, 1'b0);
            chk($sformatf("t3_level_%0d", i), fifo_level, (i < 8) ? i : 8);
            chk($sformatf("t3_overflow_%0d", i), overflow, i >= 9);
            chk($sformatf("t3_stall_up_%0d", i), stall_up, i >= 6);
        end
        chk("t3_drained_busy", drained, 0);
        drain("t3");
        chk("t3_overflow_sticky", overflow, 1);

        // Mid-operation reset with tokens queued and overflow set.
        for (int i = 0; i < 6; i++) step(1'b1, (i < 5) ? mk(501 + i) : tok_t'('0), 1'b0);
        chk("t6_pre_level", fifo_level, 5);
        rst = 1'b0;
        drv(1'b1, mk(510), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        chk("t6_level", fifo_level, 0);
        chk("t6_out_status", out_status, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_drained", drained, 1);
        chk("t6_stall_up", stall_up, 0);
        step(1'b0, mk(520), 1'b1);
        step(1'b0, '0, 1'b0);
        chk("t6_not_early", out_status, 0);
        step(1'b0, '0, 1'b0);
        chk("t6_latency", out_status, mk(520).st);
        drain("t6");

        // Alternating token/BUBBLE: dropping instance counts tokens, keeping one counts all.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i % 2 == 0) ? mk(401 + i) : tok_t'('0), 1'b1);
            chk($sformatf("t5_level_drop_%0d", i), fifo_level, (i + 1) / 2);
            chk($sformatf("t5_level_keep_%0d", i), k_fifo_level, i + 1);
        end
        drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
